// File: rtl/instr_sequencer.sv
// Instruction sequencer: a Moore FSM that captures a 16-bit instruction and
// walks the register file / ALU datapath through its read, execute and write steps.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_EXEC      = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  state_t      cur_state;
  state_t      nxt_state;
  logic [15:0] ir;
  logic [15:0] ir_nxt;
  ctrl_t       ctrl;

  // Moore output decode; evaluated on the next state so the outputs can be registered.
  function automatic ctrl_t outputs_for(input state_t st, input logic [15:0] r);
    ctrl_t c;
    logic  is_alu;
    logic  is_cmp;
    logic  is_movr;
    c       = '0;
    is_alu  = (r[15:13] == 3'b101);
    is_cmp  = is_alu && (r[12:11] == 2'b01);
    is_movr = (r[15:13] == 3'b110) && (r[12:11] == 2'b00);
    case (st)
      S_WAIT:  c.w = 1'b1;
      S_GET_A: begin
        c.readnum = r[10:8];
        c.loada   = 1'b1;
      end
      S_GET_B: begin
        c.readnum = r[2:0];
        c.loadb   = 1'b1;
      end
      S_EXEC: begin
        c.shift = r[4:3];
        c.bsel  = 1'b0;
        c.asel  = is_movr || (is_alu && (r[12:11] == 2'b11));
        c.aluop = is_alu ? r[12:11] : 2'b00;
        c.loadc = !is_cmp;
        c.loads = is_alu;
      end
      S_WRITE_REG: begin
        c.writenum = r[7:5];
        c.vsel     = 2'b00;
        c.write    = 1'b1;
      end
      S_WRITE_IMM: begin
        c.writenum = r[10:8];
        c.vsel     = 2'b10;
        c.write    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt_state = cur_state;
    ir_nxt    = ir;
    case (cur_state)
      S_WAIT: begin
        if (s) begin
          ir_nxt    = in;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10)      nxt_state = S_WRITE_IMM;
        else if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) nxt_state = S_GET_B;
        else if (ir[15:13] == 3'b101 && ir[12:11] == 2'b11) nxt_state = S_GET_B;
        else if (ir[15:13] == 3'b101)                       nxt_state = S_GET_A;
        else                                                nxt_state = S_WAIT;
      end
      S_GET_A:     nxt_state = S_GET_B;
      S_GET_B:     nxt_state = S_EXEC;
      S_EXEC:      nxt_state = (ir[15:13] == 3'b101 && ir[12:11] == 2'b01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: nxt_state = S_WAIT;
      S_WRITE_IMM: nxt_state = S_WAIT;
      default:     nxt_state = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_WAIT;
      ir        <= '0;
      ctrl      <= outputs_for(S_WAIT, 16'h0000);
    end else begin
      cur_state <= nxt_state;
      ir        <= ir_nxt;
      ctrl      <= outputs_for(nxt_state, ir_nxt);
    end
  end

  assign w        = ctrl.w;
  assign readnum  = ctrl.readnum;
  assign writenum = ctrl.writenum;
  assign write    = ctrl.write;
  assign loada    = ctrl.loada;
  assign loadb    = ctrl.loadb;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign asel     = ctrl.asel;
  assign bsel     = ctrl.bsel;
  assign vsel     = ctrl.vsel;
  assign shift    = ctrl.shift;
  assign ALUop    = ctrl.aluop;
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};
  assign state    = cur_state;

endmodule
